data_sramlike_bridge: RTL and testbench

- Mem-stage bridge directly downstream of the byte/halfword memory-select logic.
- Takes the single-cycle CPU data request (byte-enable write mask, aligned address, replicated write data, size) and drives an SRAM-like split handshake (req/addr_ok, data_ok).
- Returns read data to the mem-select logic and raises a pipeline stall until the access completes.
- Holds the returned read word while the rest of the pipeline is stalled, so each instruction issues exactly one bus transaction.

---
 rtl/data_sramlike_bridge.sv | 101 ++++++++++
 tb/tb_data_sramlike_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sramlike_bridge.sv
// data_sramlike_bridge: mem-stage CPU data request -> SRAM-like split bus.
// Issues exactly one bus transaction per instruction. It stalls the pipeline
// until data_ok arrives. It holds the returned word while other stall sources
// keep the pipeline frozen.
// Optional build macro DATA_ADDR_MAP_EN: when defined, kseg0/kseg1 addresses
// (addr[31:30]==2'b10) have bits [31:29] cleared on the bus side.
module data_sramlike_bridge #(
    parameter int WAIT_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_data_en,
    input  logic [3:0]            cpu_data_wen,
    input  logic [31:0]           cpu_data_addr,
    input  logic [31:0]           cpu_data_wdata,
    input  logic [1:0]            cpu_data_size,
    input  logic                  cpu_longest_stall,
    output logic [31:0]           cpu_data_rdata,
    output logic                  d_stall,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [31:0]           data_addr,
    output logic [31:0]           data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [31:0]           data_rdata,
    output logic [WAIT_CNT_W-1:0] data_wait_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_rdata_buf;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  w_done;
    logic                  w_accept;

    // Access completes in the data_ok cycle; data_ok seen elsewhere is stray.
    assign w_done   = (r_state == S_WAIT) && data_data_ok;
    assign w_accept = (r_state == S_IDLE) && cpu_data_en && data_addr_ok;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_WAIT;
            S_WAIT: if (data_data_ok) w_next = cpu_longest_stall ? S_HOLD : S_IDLE;
            S_HOLD: if (!cpu_longest_stall) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake, stall and read-data outputs
    always_comb begin
        data_req       = cpu_data_en && (r_state == S_IDLE);
        d_stall        = cpu_data_en && !w_done && (r_state != S_HOLD);
        cpu_data_rdata = w_done ? data_rdata : r_rdata_buf;
    end

    // Read buffer: keeps the returned word while the pipeline stays frozen
    always_ff @(posedge clk) begin
        if (rst)         r_rdata_buf <= 32'd0;
        else if (w_done) r_rdata_buf <= data_rdata;
    end

    // Wait counter: counts every cycle spent in WAIT, including the data_ok cycle
    always_ff @(posedge clk) begin
        if (rst)
            r_wait_cnt <= '0;
        else if (w_accept)
            r_wait_cnt <= '0;
        else if (r_state == S_WAIT && r_wait_cnt != {WAIT_CNT_W{1'b1}})
            r_wait_cnt <= r_wait_cnt + 1'b1;
    end

    assign data_wait_cnt = r_wait_cnt;
    assign data_wr       = |cpu_data_wen;
    assign data_size     = cpu_data_size;
    assign data_wdata    = cpu_data_wdata;

`ifdef DATA_ADDR_MAP_EN
    // kseg0/kseg1 fold onto the low 512 MB physical window
    assign data_addr = (cpu_data_addr[31:30] == 2'b10) ?
                       {3'b000, cpu_data_addr[28:0]} : cpu_data_addr;
`else
    assign data_addr = cpu_data_addr;
`endif

endmodule

// File: tb/tb_data_sramlike_bridge.sv
// Bench for data_sramlike_bridge: each access is described by its bus timing
// (addr_ok delay, data_ok delay, extra hold cycles). Expected per-cycle
// outputs come from that timeline.
module tb_data_sramlike_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_data_en = 1'b0;
    logic [3:0]  cpu_data_wen = 4'd0;
    logic [31:0] cpu_data_addr = 32'd0;
    logic [31:0] cpu_data_wdata = 32'd0;
    logic [1:0]  cpu_data_size = 2'd0;
    logic        cpu_longest_stall = 1'b0;
    logic [31:0] cpu_data_rdata;
    logic        d_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'd0;
    logic [7:0]  data_wait_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] buf_model = 32'd0;   // last word delivered by a completed access
    int          req_count = 0;       // cycles with data_req high

    data_sramlike_bridge #(.WAIT_CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_data_en(cpu_data_en), .cpu_data_wen(cpu_data_wen),
        .cpu_data_addr(cpu_data_addr), .cpu_data_wdata(cpu_data_wdata),
        .cpu_data_size(cpu_data_size), .cpu_longest_stall(cpu_longest_stall),
        .cpu_data_rdata(cpu_data_rdata), .d_stall(d_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .data_wait_cnt(data_wait_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef DATA_ADDR_MAP_EN
        return (a[31:30] == 2'b10) ? (a & 32'h1FFF_FFFF) : a;
`else
        return a;
`endif
    endfunction

    // One access: req at cycle 0, addr_ok at cycle a, data_ok at cycle a+d,
    // other stall held through h further cycles after data_ok (h=0: none).
    task automatic run_access(input int a, input int d, input int h,
                              input logic [3:0] wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size,
                              input logic [31:0] rd);
        int t_ok;
        int last;
        int exp_cnt;
        t_ok = a + d;
        last = (h > 0) ? t_ok + h + 1 : t_ok;
        cpu_data_en    = 1'b1;
        cpu_data_wen   = wen;
        cpu_data_addr  = addr;
        cpu_data_wdata = wdata;
        cpu_data_size  = size;
        for (int c = 0; c <= last; c++) begin
            data_addr_ok      = (c == a);
            data_data_ok      = (c == t_ok) || (c > t_ok && $urandom_range(0, 2) == 0);
            data_rdata        = (c == t_ok) ? rd : $urandom;
            cpu_longest_stall = (c < t_ok) ? 1'($urandom_range(0, 1)) : (c < last);
            @(negedge clk);
            if (data_req) req_count++;
            n_checks++;
            if (data_req !== (c <= a)) begin
                n_fail++; $display("FAIL req c=%0d got %b exp %b", c, data_req, (c <= a));
            end
            n_checks++;
            if (d_stall !== (c < t_ok)) begin
                n_fail++; $display("FAIL stall c=%0d got %b exp %b", c, d_stall, (c < t_ok));
            end
            n_checks++;
            if (cpu_data_rdata !== ((c >= t_ok) ? rd : buf_model)) begin
                n_fail++; $display("FAIL rdata c=%0d got %h exp %h", c, cpu_data_rdata,
                                   (c >= t_ok) ? rd : buf_model);
            end
            n_checks++;
            if ({data_wr, data_size, data_addr, data_wdata} !==
                {(wen != 4'd0), size, exp_addr(addr), wdata}) begin
                n_fail++; $display("FAIL fwd c=%0d got wr=%b sz=%0d a=%h wd=%h exp wr=%b sz=%0d a=%h wd=%h",
                                   c, data_wr, data_size, data_addr, data_wdata,
                                   (wen != 4'd0), size, exp_addr(addr), wdata);
            end
            @(posedge clk); #1;
        end
        buf_model = rd;
        exp_cnt = (d > 255) ? 255 : d;
        // next cycle: instruction gone, stray data_ok may appear on the bus
        cpu_data_en = 1'b0; data_addr_ok = 1'b0; cpu_longest_stall = 1'b0;
        data_data_ok = 1'($urandom_range(0, 1)); data_rdata = $urandom;
        @(negedge clk);
        n_checks++;
        if (data_wait_cnt !== 8'(exp_cnt) || cpu_data_rdata !== rd || d_stall !== 1'b0 || data_req !== 1'b0) begin
            n_fail++; $display("FAIL post cnt=%0d/%0d rdata=%h/%h stall=%b req=%b",
                               data_wait_cnt, exp_cnt, cpu_data_rdata, rd, d_stall, data_req);
        end
        @(posedge clk); #1;
        data_data_ok = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; cpu_data_en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (data_req !== 1'b0 || d_stall !== 1'b0 || cpu_data_rdata !== 32'd0 || data_wait_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset req=%b stall=%b rdata=%h cnt=%0d exp 0 0 0 0",
                               data_req, d_stall, cpu_data_rdata, data_wait_cnt);
        end
        cpu_data_en = 1'b1;
        #1;
        n_checks++;
        if (d_stall !== 1'b1) begin
            n_fail++; $display("FAIL reset_stall got %b exp 1", d_stall);
        end
        @(posedge clk); #1;
        rst = 1'b0; cpu_data_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_hit;
        run_access(0, 1, 0, 4'b0000, 32'h0000_0100, 32'd0, 2'b10, 32'h1234_5678);
        n_checks++;
        if (buf_model !== 32'h1234_5678 || cpu_data_rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL read_hit_buf got %h exp 12345678", cpu_data_rdata);
        end
    endtask

    task automatic test_write_delayed;
        req_count = 0;
        run_access(3, 2, 0, 4'b0100, 32'h0000_0006, 32'hABAB_ABAB, 2'b00, 32'h5555_0000);
        n_checks++;
        if (req_count !== 4) begin
            n_fail++; $display("FAIL write_req_cycles got %0d exp 4", req_count);
        end
    endtask

    task automatic test_hold;
        req_count = 0;
        run_access(0, 2, 3, 4'b0000, 32'h0000_2000, 32'd0, 2'b10, 32'hCAFE_F00D);
        n_checks++;
        if (req_count !== 1) begin
            n_fail++; $display("FAIL hold_req_cycles got %0d exp 1", req_count);
        end
    endtask

    task automatic test_reset_midflight;
        cpu_data_en = 1'b1; cpu_data_wen = 4'd0; cpu_data_addr = 32'h40;
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (d_stall !== 1'b1 || data_req !== 1'b0) begin
            n_fail++; $display("FAIL midflight_wait stall=%b req=%b exp 1 0", d_stall, data_req);
        end
        @(posedge clk); #1;
        rst = 1'b0; cpu_data_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (cpu_data_rdata !== 32'd0 || data_wait_cnt !== 8'd0 || data_req !== 1'b0 || d_stall !== 1'b0) begin
            n_fail++; $display("FAIL midflight_stray rdata=%h cnt=%0d req=%b stall=%b exp 0 0 0 0",
                               cpu_data_rdata, data_wait_cnt, data_req, d_stall);
        end
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cpu_data_rdata !== 32'd0 || data_wait_cnt !== 8'd0) begin
            n_fail++; $display("FAIL midflight_after rdata=%h cnt=%0d exp 0 0", cpu_data_rdata, data_wait_cnt);
        end
        buf_model = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_saturate;
        run_access(1, 300, 0, 4'b0000, 32'h0000_3000, 32'd0, 2'b10, 32'h0BAD_CAFE);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (data_wait_cnt !== 8'd255) begin
                n_fail++; $display("FAIL sat_hold i=%0d got %0d exp 255", i, data_wait_cnt);
            end
            @(posedge clk); #1;
        end
        run_access(0, 2, 0, 4'b0000, 32'h0000_3004, 32'd0, 2'b10, 32'h0000_0042);
    endtask

    task automatic test_addr_map;
        logic [31:0] addrs [3];
        logic [31:0] exps  [3];
        addrs[0] = 32'hBFC0_1000; addrs[1] = 32'h0000_1000; addrs[2] = 32'h8000_0010;
`ifdef DATA_ADDR_MAP_EN
        exps[0] = 32'h1FC0_1000; exps[1] = 32'h0000_1000; exps[2] = 32'h0000_0010;
`else
        exps[0] = 32'hBFC0_1000; exps[1] = 32'h0000_1000; exps[2] = 32'h8000_0010;
`endif
        for (int i = 0; i < 3; i++) begin
            cpu_data_addr = addrs[i];
            #1;
            n_checks++;
            if (data_addr !== exps[i]) begin
                n_fail++; $display("FAIL addr_map in=%h got %h exp %h", addrs[i], data_addr, exps[i]);
            end
        end
        run_access(0, 1, 0, 4'b1111, 32'hBFC0_1000, 32'h1111_2222, 2'b10, 32'h7777_8888);
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            logic [3:0] wen;
            wen = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            run_access($urandom_range(0, 3), $urandom_range(1, 5), $urandom_range(0, 3),
                       wen, $urandom & 32'hFFFF_FFFC, $urandom, 2'($urandom_range(0, 2)), $urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                data_data_ok = 1'($urandom_range(0, 1)); data_rdata = $urandom;
                @(negedge clk);
                n_checks++;
                if (cpu_data_rdata !== buf_model || d_stall !== 1'b0 || data_req !== 1'b0) begin
                    n_fail++; $display("FAIL idle_gap rdata=%h/%h stall=%b req=%b",
                                       cpu_data_rdata, buf_model, d_stall, data_req);
                end
                @(posedge clk); #1;
                data_data_ok = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset;
        test_read_hit;
        test_write_delayed;
        test_hold;
        test_reset_midflight;
        test_saturate;
        test_addr_map;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
